// File: rtl/regbank_wb_arbiter.sv
// Write-port sequencer for the 16x32 register bank: round-robin arbitration of two
// writeback requesters, a registered write port and a pending-write scoreboard.
module regbank_wb_arbiter #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_dest,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_dest,
  input  logic [DW-1:0]   b_data,
  output logic            b_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_dest,
  output logic [DW-1:0]   rf_din,
  input  logic            claim_valid,
  input  logic [AW-1:0]   claim_dest,
  output logic            claim_ok,
  input  logic [AW-1:0]   srcadd1,
  input  logic [AW-1:0]   srcadd2,
  output logic            busy1,
  output logic            busy2,
  output logic [NREG-1:0] pending
);

  typedef enum logic {PRI_A, PRI_B} pri_t;

  pri_t            pri_q, pri_d;
  logic            wr_acc;
  logic [AW-1:0]   wr_dest;
  logic [DW-1:0]   wr_data;
  logic [NREG-1:0] pend_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pri_q <= PRI_A;
    else     pri_q <= pri_d;
  end

  // The pointer moves to the requester that was not served, so contention alternates.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    pri_d   = pri_q;
    if (a_valid && (!b_valid || pri_q == PRI_A)) a_ready = 1'b1;
    else if (b_valid)                            b_ready = 1'b1;
    if (a_ready)      pri_d = PRI_B;
    else if (b_ready) pri_d = PRI_A;
  end

  assign wr_acc  = a_ready | b_ready;
  assign wr_dest = a_ready ? a_dest : b_dest;
  assign wr_data = a_ready ? a_data : b_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_dest <= '0;
      rf_din  <= '0;
    end else begin
      rf_we <= wr_acc;
      if (wr_acc) begin
        rf_dest <= wr_dest;
        rf_din  <= wr_data;
      end
    end
  end

  assign claim_ok = claim_valid && !pending[claim_dest];

  // Set is applied after clear so a same-edge claim of the written register wins.
  always_comb begin
    pend_d = pending;
    if (wr_acc)   pend_d[wr_dest]    = 1'b0;
    if (claim_ok) pend_d[claim_dest] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pend_d;
  end

  assign busy1 = pending[srcadd1];
  assign busy2 = pending[srcadd2];

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: an abstract model checked every cycle plus
// literal expectations at the interesting points of each scenario.
module tb_regbank_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, claim_valid = 1'b0;
  logic [3:0]  a_dest = '0, b_dest = '0, claim_dest = '0, srcadd1 = '0, srcadd2 = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, rf_we, claim_ok, busy1, busy2;
  logic [3:0]  rf_dest;
  logic [31:0] rf_din;
  logic [15:0] pending;

  int checks = 0;
  int fails  = 0;

  regbank_wb_arbiter #(.NREG(16), .AW(4), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_din(rf_din),
    .claim_valid(claim_valid), .claim_dest(claim_dest), .claim_ok(claim_ok),
    .srcadd1(srcadd1), .srcadd2(srcadd2), .busy1(busy1), .busy2(busy2),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model state: reserved registers, who was served last, and the write owed to the bank.
  bit          m_res[16];
  int          m_last = -1;   // -1 none since reset, 0 = A, 1 = B
  bit          m_we = 0;
  logic [3:0]  m_dest = '0;
  logic [31:0] m_din = '0;
  bit          n_res[16];
  int          n_last;
  bit          n_we;
  logic [3:0]  n_dest;
  logic [31:0] n_din;

  always @(negedge clk) begin
    bit          ea, eb, eclaim;
    logic [15:0] epend;
    ea = 0; eb = 0;
    if (a_valid && b_valid) begin
      if (m_last == 0) eb = 1; else ea = 1;
    end else begin
      ea = a_valid;
      eb = b_valid;
    end
    eclaim = claim_valid && !m_res[claim_dest];
    for (int i = 0; i < 16; i++) epend[i] = m_res[i];
    chk("model.a_ready", a_ready, ea);
    chk("model.b_ready", b_ready, eb);
    chk("model.claim_ok", claim_ok, eclaim);
    chk("model.pending", pending, epend);
    chk("model.busy1", busy1, m_res[srcadd1]);
    chk("model.busy2", busy2, m_res[srcadd2]);
    chk("model.rf_we", rf_we, m_we);
    chk("model.rf_dest", rf_dest, m_dest);
    chk("model.rf_din", rf_din, m_din);
    n_res = m_res;
    n_last = m_last;
    n_we = ea || eb;
    n_dest = m_dest;
    n_din = m_din;
    if (ea) begin n_last = 0; n_dest = a_dest; n_din = a_data; n_res[a_dest] = 0; end
    if (eb) begin n_last = 1; n_dest = b_dest; n_din = b_data; n_res[b_dest] = 0; end
    if (eclaim) n_res[claim_dest] = 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_res[i] = 0;
      m_last = -1; m_we = 0; m_dest = '0; m_din = '0;
    end else begin
      m_res = n_res; m_last = n_last; m_we = n_we; m_dest = n_dest; m_din = n_din;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    chk("reset.rf_we", rf_we, 0);
    chk("reset.pending", pending, 16'h0);
    chk("reset.rf_din", rf_din, 32'h0);

    // Reset mid-stream: beat in flight and a same-edge claim of its register
    rst = 1'b0;
    a_valid = 1; a_dest = 4'd9; a_data = 32'h99;
    claim_valid = 1; claim_dest = 4'd9;
    step();
    a_valid = 0; claim_valid = 0;
    chk("midrst.rf_we_before", rf_we, 1);
    chk("midrst.pend9_before", pending[9], 1);
    rst = 1'b1;
    #1;
    chk("midrst.rf_we", rf_we, 0);
    chk("midrst.pending", pending, 16'h0);
    step();
    rst = 1'b0;
    b_valid = 1; b_dest = 4'd6; b_data = 32'h66;
    #1;
    chk("midrst.b_ready", b_ready, 1);
    step();
    b_valid = 0;

    // Single write from A
    a_valid = 1; a_dest = 4'd1; a_data = 32'h1;
    #1;
    chk("single.a_ready", a_ready, 1);
    step();
    a_valid = 0;
    chk("single.rf_we", rf_we, 1);
    chk("single.rf_dest", rf_dest, 4'd1);
    chk("single.rf_din", rf_din, 32'h1);
    step();
    chk("single.rf_we_off", rf_we, 0);

    // Contention from reset: A, B, A, B
    rst = 1'b1;
    a_valid = 1; a_dest = 4'd2; a_data = 32'hA;
    b_valid = 1; b_dest = 4'd3; b_data = 32'hB;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("cont.a_ready", a_ready, (i % 2) == 0);
      chk("cont.b_ready", b_ready, (i % 2) == 1);
      step();
      chk("cont.rf_we", rf_we, 1);
      chk("cont.rf_dest", rf_dest, ((i % 2) == 0) ? 4'd2 : 4'd3);
    end
    a_valid = 0; b_valid = 0;
    step();

    // Claim, reclaim, clear via B
    claim_valid = 1; claim_dest = 4'd5; srcadd1 = 4'd5; srcadd2 = 4'd5;
    #1;
    chk("claim.ok", claim_ok, 1);
    step();
    chk("claim.pend5", pending[5], 1);
    chk("claim.busy1", busy1, 1);
    chk("claim.busy2", busy2, 1);
    chk("claim.reclaim", claim_ok, 0);
    claim_valid = 0;
    b_valid = 1; b_dest = 4'd5; b_data = 32'h55;
    #1;
    chk("clear.b_ready", b_ready, 1);
    chk("clear.pend5_same", pending[5], 1);
    step();
    b_valid = 0;
    chk("clear.pend5", pending[5], 0);
    chk("clear.busy1", busy1, 0);
    chk("clear.rf_din", rf_din, 32'h55);

    // Simultaneous set and clear of reg 7
    chk("simul.pend7_pre", pending[7], 0);
    a_valid = 1; a_dest = 4'd7; a_data = 32'h77;
    claim_valid = 1; claim_dest = 4'd7; srcadd2 = 4'd7;
    #1;
    chk("simul.claim_ok", claim_ok, 1);
    chk("simul.a_ready", a_ready, 1);
    step();
    a_valid = 0; claim_valid = 0;
    chk("simul.pend7", pending[7], 1);
    chk("simul.busy2", busy2, 1);

    // Idle hold after a write of DEADBEEF to reg 4
    a_valid = 1; a_dest = 4'd4; a_data = 32'hDEADBEEF;
    step();
    a_valid = 0;
    chk("idle.rf_we_pulse", rf_we, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle.rf_we", rf_we, 0);
      chk("idle.rf_din", rf_din, 32'hDEADBEEF);
      chk("idle.rf_dest", rf_dest, 4'd4);
    end
    // A was served last, so contention must now go to B
    a_valid = 1; a_dest = 4'd8; a_data = 32'h8;
    b_valid = 1; b_dest = 4'd9; b_data = 32'h9;
    #1;
    chk("idle.ptr_b_ready", b_ready, 1);
    chk("idle.ptr_a_ready", a_ready, 0);
    step();
    b_valid = 0;
    #1;
    chk("idle.a_after", a_ready, 1);
    step();
    a_valid = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end
endmodule
